// File: rtl/audio_sample_player.sv
// rtl/audio_sample_player.sv - sample-rate driven memory fetch with PWM DAC output
//
// Purpose:
//   On each synchronized rising edge of tick_in, fetches one sample from sample
//   memory over a rd/valid handshake. The sample is held and converted to a
//   PWM bit stream at the system clock rate.
//
// Optional feature macro: PLAYER_LOOP_EN
//   defined   - after end_addr playback restarts at start_addr; done never rises.
//   undefined - after end_addr the player parks in DONE and holds the last sample.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   tick_in     sample-rate clock from the divider (asynchronous to clk)
//   play        1-cycle pulse, start playback (ignored while busy)
//   stop        1-cycle pulse, abort playback (wins over play)
//   start_addr  first sample address, latched on play
//   end_addr    last sample address (inclusive), latched on play
//   mem_addr    sample memory address
//   mem_rd      1-cycle read strobe
//   mem_data    read data, qualified by mem_valid
//   mem_valid   read data valid
//   pwm_out     registered PWM DAC output
//   busy        high in every state except IDLE and DONE
//   done        high in DONE
//   underrun    sticky: a tick arrived while a fetch was still outstanding

module audio_sample_player #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_in,
  input  logic              play,
  input  logic              stop,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic              pwm_out,
  output logic              busy,
  output logic              done,
  output logic              underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};

  state_t            state;
  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] end_q;
  logic [DATA_W-1:0] sample_q;
  logic [DATA_W-1:0] pwm_cnt;
  logic [1:0]        sync;
  logic              tick_prev;
  logic              tick;

  // tick_in is asynchronous: two flops for metastability, a third to find the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync      <= 2'b00;
      tick_prev <= 1'b0;
    end else begin
      sync      <= {sync[0], tick_in};
      tick_prev <= sync[1];
    end
  end

  assign tick = sync[1] & ~tick_prev;

  // Free-running PWM; a new sample takes effect on the very next compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + DATA_W'(1);
      pwm_out <= (pwm_cnt < sample_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      start_q  <= '0;
      end_q    <= '0;
      sample_q <= MIDSCALE;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      if (stop) begin
        // Abort from anywhere; a late mem_valid lands in IDLE and is ignored.
        state <= S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (play) begin
              start_q  <= start_addr;
              end_q    <= end_addr;
              mem_addr <= start_addr;
              underrun <= 1'b0;
              busy     <= 1'b1;
              done     <= 1'b0;
              state    <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (tick) begin
              mem_rd <= 1'b1;
              state  <= S_FETCH;
            end
          end
          S_FETCH: begin
            if (tick) underrun <= 1'b1;
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (tick) underrun <= 1'b1;
            if (mem_valid) begin
              sample_q <= mem_data;
              state    <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (tick) underrun <= 1'b1;
            if (mem_addr == end_q) begin
`ifdef PLAYER_LOOP_EN
              mem_addr <= start_q;
              state    <= S_ARMED;
`else
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
`endif
            end else begin
              // Wraps modulo 2**ADDR_W, so start_addr > end_addr plays through zero.
              mem_addr <= mem_addr + ADDR_W'(1);
              state    <= S_ARMED;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_player.sv
// tb/tb_audio_sample_player.sv - scoreboard bench for audio_sample_player

module tb_audio_sample_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_in;
  logic        play;
  logic        stop;
  logic [15:0] start_addr;
  logic [15:0] end_addr;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        mem_valid;
  logic        pwm_out;
  logic        busy;
  logic        done;
  logic        underrun;

  audio_sample_player #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .play(play), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_data(mem_data), .mem_valid(mem_valid),
    .pwm_out(pwm_out), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

`ifdef PLAYER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  mem_img[int];
  int          mem_delay = 2;

  // Reference model: a playback is a list of addresses consumed one per tick.
  bit          playing = 1'b0;
  bit          exp_done = 1'b0;
  logic [15:0] m_start, m_end, m_cur;
  logic [7:0]  exp_sample = 8'd128;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] img_of(input logic [15:0] a);
    if (mem_img.exists(int'(a))) return mem_img[int'(a)];
    return 8'h00;
  endfunction

  // Scoreboard monitor: every read strobe must match the next expected address.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_rd === 1'b1) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_read: addr 0x%0h with no read expected", mem_addr);
        end else begin
          check("read_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Memory responder with programmable latency.
  initial begin
    logic [15:0] a;
    mem_valid = 1'b0;
    mem_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_rd === 1'b1 && reset === 1'b0) begin
        a = mem_addr;
        repeat (mem_delay) @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_data  = img_of(a);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_data  = 8'($urandom);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_play(input logic [15:0] s, input logic [15:0] e);
    start_addr = s;
    end_addr   = e;
    play = 1'b1;
    cyc(1);
    play = 1'b0;
    if (!playing) begin
      m_start = s; m_end = e; m_cur = s;
      playing = 1'b1;
      exp_done = 1'b0;
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    playing = 1'b0;
    exp_done = 1'b0;
  endtask

  task automatic tick_model();
    if (playing) begin
      exp_q.push_back(m_cur);
      exp_sample = img_of(m_cur);
      if (m_cur == m_end) begin
        if (LOOP) m_cur = m_start;
        else begin
          playing = 1'b0;
          exp_done = 1'b1;
        end
      end else begin
        m_cur = m_cur + 16'd1;
      end
    end
  endtask

  task automatic do_tick(input int spacing);
    tick_model();
    tick_in = 1'b1;
    cyc(1);
    tick_in = 1'b0;
    cyc(spacing - 1);
  endtask

  task automatic wait_rd();
    int n = 0;
    while (mem_rd !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rd_seen_in_budget", 32'(n < 50), 32'd1);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(playing));
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_reads_outstanding"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_duty(input string name, input logic [7:0] exp);
    int cnt = 0;
    repeat (256) begin
      @(negedge clk);
      cnt += int'(pwm_out);
    end
    check(name, 32'(cnt), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] s, e, old_sample;
    int len;

    reset = 1'b1; tick_in = 1'b0; play = 1'b0; stop = 1'b0;
    start_addr = 16'h0; end_addr = 16'h0;
    cyc(3);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_pwm_out", 32'(pwm_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    cyc(2);
    check_duty("idle_duty_midscale", 8'd128);
    do_tick(20);
    check_status("idle");

    // Directed playback 0x10..0x12 at the real sample period, plus one extra tick.
    mem_delay = 2;
    for (int i = 16; i <= 18; i++) mem_img[i] = 8'($urandom);
    do_play(16'h0010, 16'h0012);
    for (int k = 0; k < 4; k++) do_tick(2269);
    check_status("directed");
    check_duty("directed_duty", exp_sample);
    do_stop();
    cyc(2);
    check_status("directed_stopped");

    // Underrun: second tick three clocks after the first with a slow memory.
    mem_delay = 5;
    for (int i = 'h30; i <= 'h33; i++) mem_img[i] = 8'($urandom);
    do_play(16'h0030, 16'h0033);
    tick_model();
    tick_in = 1'b1; cyc(1); tick_in = 1'b0; cyc(2);
    tick_in = 1'b1; cyc(1); tick_in = 1'b0; cyc(30);
    check("underrun_set", 32'(underrun), 32'd1);
    check_status("underrun");
    do_tick(40);
    check("underrun_sticky", 32'(underrun), 32'd1);
    do_stop();
    do_play(16'h0040, 16'h0040);
    cyc(2);
    check("underrun_cleared_on_play", 32'(underrun), 32'd0);
    do_stop();

    // Duty extremes and a random level.
    for (int i = 0; i < 4; i++) begin
      s = 16'h0100 + 16'(i);
      mem_img[int'(s)] = (i == 0) ? 8'h00 : (i == 1) ? 8'h40 : (i == 2) ? 8'hFF : 8'($urandom);
      mem_delay = $urandom_range(1, 4);
      do_play(s, s);
      do_tick(30);
      check_status("duty_play");
      check_duty("duty_level", exp_sample);
      do_stop();
    end

    // Randomized playbacks; the first wraps through address zero.
    for (int it = 0; it < 6; it++) begin
      if (it == 0) begin
        s = 16'hFFFE; len = 4;
      end else begin
        s = 16'($urandom); len = $urandom_range(1, 5);
      end
      e = s + 16'(len - 1);
      for (int i = 0; i < len; i++) mem_img[int'(16'(s + 16'(i)))] = 8'($urandom);
      mem_delay = $urandom_range(1, 4);
      do_play(s, e);
      for (int k = 0; k < len + 1; k++) begin
        do_tick($urandom_range(20, 60));
        if (k == 0 && (it % 2) == 1) do_play(16'($urandom), 16'($urandom));
      end
      cyc(10);
      check_status("random");
      check_duty("random_duty", exp_sample);
      do_stop();
      check("random_stopped_busy", 32'(busy), 32'd0);
    end

    // Stop while waiting on memory: late data must not reach the DAC.
    mem_delay = 5;
    old_sample = exp_sample;
    mem_img['h200] = exp_sample ^ 8'hA5;
    do_play(16'h0200, 16'h0205);
    tick_model();
    tick_in = 1'b1; cyc(1); tick_in = 1'b0;
    wait_rd();
    @(posedge clk); #1;
    do_stop();
    exp_sample = old_sample;
    cyc(20);
    check_status("stop_in_wait");
    check_duty("stop_in_wait_duty", exp_sample);

    // play and stop together: stop wins.
    start_addr = 16'h0300; end_addr = 16'h0301;
    play = 1'b1; stop = 1'b1;
    cyc(1);
    play = 1'b0; stop = 1'b0;
    cyc(2);
    check("play_stop_same_busy", 32'(busy), 32'd0);
    do_tick(20);

    // Asynchronous reset during the read strobe.
    mem_delay = 3;
    mem_img['h400] = 8'h11;
    do_play(16'h0400, 16'h0401);
    tick_model();
    tick_in = 1'b1; cyc(1); tick_in = 1'b0;
    wait_rd();
    reset = 1'b1;
    #1;
    check("async_rst_mem_rd", 32'(mem_rd), 32'd0);
    check("async_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    cyc(2);
    reset = 1'b0;
    playing = 1'b0; exp_done = 1'b0; exp_sample = 8'd128;
    cyc(20);
    check_status("after_reset");
    check_duty("after_reset_duty", exp_sample);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
